conv33_acc: RTL
===============

CONV33_ACC -- requirements
Module: conv33_acc

Interface
REQ-001 SHALL have parameter DATA_W, default 8, signed activation width.
REQ-002 SHALL have parameter WEIGHT_W, default 8, signed weight width.
REQ-003 SHALL have parameter ACC_W, default 32, signed accumulator, bias and acc_out width.
REQ-004 SHALL have parameter OUT_W, default 8, signed width of the saturated result.
REQ-005 SHALL have parameter IN_CH, default 4, number of input-channel beats per output (1..256).
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst  in  1  reset, synchronous and active-high.
REQ-008 conv33_en  in  1  beat valid; window and weights sampled when high.
REQ-009 clr  in  1  synchronous soft abort of the partial group.
REQ-010 data  in  9*DATA_W  packed 3x3 window, element r*3+c at bits [(r*3+c)*DATA_W +: DATA_W].
REQ-011 weight  in  9*WEIGHT_W  packed kernel, same ordering as data.
REQ-012 bias  in  ACC_W  signed bias, sampled on the first beat of each group.
REQ-013 relu_en  in  1  clamp negative accumulated value to 0 before shift.
REQ-014 shift  in  5  arithmetic right-shift amount applied before saturation.
REQ-015 result  out  OUT_W  shifted, saturated signed output.
REQ-016 acc_out  out  ACC_W  full-precision accumulated sum including bias, before ReLU/shift.
REQ-017 valid  out  1  one-cycle pulse qualifying result and acc_out.
REQ-018 busy  out  1  high while channel count is nonzero or any pipeline stage holds a beat.

Function
REQ-019 No back-pressure: SHALL accept a beat on every cycle conv33_en is high, including back-to-back and with idle gaps.
REQ-020 Stage 1 SHALL register nine signed products, each DATA_W+WEIGHT_W bits.
REQ-021 Stage 2 SHALL register three row sums, each product width +2 bits, sign-extended.
REQ-022 Stage 3 SHALL form the window sum (product width +4 bits) and update the accumulator.
REQ-023 On a group's first beat, the accumulator SHALL load bias + window sum; on later beats it SHALL load acc + window sum.
REQ-024 The channel counter SHALL advance 0..IN_CH-1 per accepted beat and wrap to 0 after the last beat; the first/last tags SHALL travel with the beat through the pipeline.
REQ-025 Stage 4 SHALL register acc_out, result and valid=1 for the last beat only, 4 clocks after that beat's sampling edge.
REQ-026 Post-processing SHALL be: v = (relu_en && acc<0) ? 0 : acc; v >>>= shift; saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-027 relu_en and shift SHALL be sampled with the last beat and carried in the pipeline; mid-group changes SHALL NOT affect the result.
REQ-028 A beat with first and last set (IN_CH=1) SHALL load bias + sum and produce output.
REQ-029 clr SHALL zero the channel counter and all pipeline valid tags at the next edge, suppressing pending valid pulses; if conv33_en is high in the same cycle, clr SHALL win and the beat is dropped.
REQ-030 Outside valid cycles, result and acc_out SHALL hold their last values.
REQ-031 Elaboration SHALL fail if ACC_W < DATA_W+WEIGHT_W+5+clog2(IN_CH).

Reset
REQ-032 rst SHALL clear result, acc_out, valid, busy, the accumulator, the channel counter and all pipeline tags to 0; beats in flight SHALL be discarded.
REQ-033 rst SHALL take priority over clr and conv33_en.

Structure
REQ-034 A shared package conv_pkg SHALL hold the default width constants, the saturate/shift helper function and the stage-tag struct (valid, first, last, relu_en, shift).
REQ-035 One sub-module, conv33_mul_tree, SHALL implement stages 1-2; conv33_acc SHALL hold the counter, accumulator and post-process.

Verification
REQ-036 IN_CH=1, data 1..9, weights all 1, bias 1, shift 0, relu_en 0 -> valid 4 clocks after the beat, acc_out=46, result=46.
REQ-037 IN_CH=4, same window on 4 back-to-back beats, bias 1 -> one valid, acc_out=181, result=127 (saturated); repeated with shift=1 -> result=90.
REQ-038 IN_CH=1, data all -128, weights all 127, bias 0 -> acc_out=-146304; relu_en 0 gives result=-128; relu_en 1 gives result=0.
REQ-039 IN_CH=4, beats with 0-3 idle cycles between them -> single valid after the 4th beat; values identical to REQ-037; busy high from the first beat until the valid cycle.
REQ-040 IN_CH=4, rst (or clr) after 2 beats -> no valid; the next 4 beats give acc_out=181 (bias counted once).
REQ-041 Last beat accepted, then clr on the following cycle -> valid never asserts, busy low the next cycle.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared widths, stage tag and post-processing helper for the 3x3 conv accumulator
package conv_pkg;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_WEIGHT_W = 8;
    localparam int DEF_ACC_W    = 32;
    localparam int DEF_OUT_W    = 8;
    localparam int DEF_IN_CH    = 4;

    typedef struct packed {
        logic       valid;
        logic       first;
        logic       last;
        logic       relu_en;
        logic [4:0] shift;
    } tag_t;

    // ReLU, arithmetic shift, then clamp to a signed out_w-bit range
    function automatic logic signed [63:0] post_sat(input logic signed [63:0] acc, input logic relu,
                                                    input logic [4:0] sh, input int out_w);
        logic signed [63:0] v, hi, lo;
        v  = (relu && acc[63]) ? '0 : acc;
        v  = v >>> sh;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = ~hi;
        return (v > hi) ? hi : (v < lo) ? lo : v;
    endfunction
endpackage

// File: rtl/conv33_mul_tree.sv
// conv33_mul_tree: registered 3x3 products followed by registered sign-extended row sums
module conv33_mul_tree
    import conv_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int WEIGHT_W = DEF_WEIGHT_W
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [9*DATA_W-1:0]                     data,
    input  logic [9*WEIGHT_W-1:0]                   weight,
    output logic [3*(DATA_W+WEIGHT_W+2)-1:0]        rows
);
    localparam int PROD_W = DATA_W + WEIGHT_W;
    localparam int ROW_W  = PROD_W + 2;

    logic signed [PROD_W-1:0] prod_d [9];
    logic signed [PROD_W-1:0] prod_q [9];
    logic signed [ROW_W-1:0]  row_d  [3];
    logic signed [ROW_W-1:0]  row_q  [3];

    always_comb begin
        for (int i = 0; i < 9; i++)
            prod_d[i] = PROD_W'($signed(data[i*DATA_W +: DATA_W])) * PROD_W'($signed(weight[i*WEIGHT_W +: WEIGHT_W]));
        for (int r = 0; r < 3; r++)
            row_d[r] = ROW_W'(prod_q[3*r]) + ROW_W'(prod_q[3*r+1]) + ROW_W'(prod_q[3*r+2]);
        for (int r = 0; r < 3; r++)
            rows[r*ROW_W +: ROW_W] = row_q[r];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 9; i++)
            prod_q[i] <= rst ? '0 : prod_d[i];
        for (int r = 0; r < 3; r++)
            row_q[r] <= rst ? '0 : row_d[r];
    end
endmodule

// File: rtl/conv33_acc.sv
// conv33_acc: pipelined 3x3 MAC accumulating IN_CH channel beats plus bias, with ReLU/shift/saturate output
module conv33_acc
    import conv_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int WEIGHT_W = DEF_WEIGHT_W,
    parameter int ACC_W    = DEF_ACC_W,
    parameter int OUT_W    = DEF_OUT_W,
    parameter int IN_CH    = DEF_IN_CH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  conv33_en,
    input  logic                  clr,
    input  logic [9*DATA_W-1:0]   data,
    input  logic [9*WEIGHT_W-1:0] weight,
    input  logic [ACC_W-1:0]      bias,
    input  logic                  relu_en,
    input  logic [4:0]            shift,
    output logic [OUT_W-1:0]      result,
    output logic [ACC_W-1:0]      acc_out,
    output logic                  valid,
    output logic                  busy
);
    localparam int PROD_W = DATA_W + WEIGHT_W;
    localparam int ROW_W  = PROD_W + 2;
    localparam int WIN_W  = PROD_W + 4;
    localparam int CNT_W  = (IN_CH > 1) ? $clog2(IN_CH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_CH - 1);

    if (ACC_W < PROD_W + 5 + $clog2(IN_CH) || IN_CH < 1 || IN_CH > 256) begin : g_param_check
        $error("conv33_acc: ACC_W too narrow for IN_CH, or IN_CH outside 1..256");
    end

    logic [3*ROW_W-1:0]       rows;
    logic [CNT_W-1:0]         cnt_d, cnt_q;
    tag_t                     tag1_d, tag1_q, tag2_d, tag2_q, tag3_d, tag3_q;
    logic signed [ACC_W-1:0]  bias1_d, bias1_q, bias2_d, bias2_q;
    logic signed [ACC_W-1:0]  acc_d, acc_q, acc_out_d, acc_out_q;
    logic [OUT_W-1:0]         result_d, result_q;
    logic                     valid_d, valid_q;
    logic signed [WIN_W-1:0]  win_sum;
    logic                     accept, first, last, fire;

    conv33_mul_tree #(.DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W)) u_mul_tree (
        .clk    (clk),
        .rst    (rst),
        .data   (data),
        .weight (weight),
        .rows   (rows)
    );

    always_comb begin
        accept  = conv33_en && !clr;
        first   = cnt_q == '0;
        last    = cnt_q == LAST_CNT;
        cnt_d   = clr ? '0 : accept ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
        tag1_d  = '{valid: accept, first: first, last: last, relu_en: relu_en, shift: shift};
        tag2_d  = clr ? '0 : tag1_q;
        tag3_d  = clr ? '0 : tag2_q;
        // bias rides alongside the beat so a new group can enter while the old one drains
        bias1_d = (accept && first) ? $signed(bias) : bias1_q;
        bias2_d = bias1_q;
        win_sum = WIN_W'(signed'(rows[0 +: ROW_W])) + WIN_W'(signed'(rows[ROW_W +: ROW_W]))
                + WIN_W'(signed'(rows[2*ROW_W +: ROW_W]));
        acc_d   = (tag2_q.valid && !clr) ? (tag2_q.first ? bias2_q : acc_q) + ACC_W'(win_sum) : acc_q;
        fire    = tag3_q.valid && tag3_q.last && !clr;
        valid_d   = fire;
        acc_out_d = fire ? acc_q : acc_out_q;
        result_d  = fire ? OUT_W'(post_sat(64'(acc_q), tag3_q.relu_en, tag3_q.shift, OUT_W)) : result_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            tag1_q    <= '0;
            tag2_q    <= '0;
            tag3_q    <= '0;
            bias1_q   <= '0;
            bias2_q   <= '0;
            acc_q     <= '0;
            acc_out_q <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            tag1_q    <= tag1_d;
            tag2_q    <= tag2_d;
            tag3_q    <= tag3_d;
            bias1_q   <= bias1_d;
            bias2_q   <= bias2_d;
            acc_q     <= acc_d;
            acc_out_q <= acc_out_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
        end
    end

    assign result  = result_q;
    assign acc_out = acc_out_q;
    assign valid   = valid_q;
    assign busy    = cnt_q != '0 || tag1_q.valid || tag2_q.valid || tag3_q.valid;
endmodule
